// File: rtl/vocab_tokenizer_pkg.sv
// Shared types and helpers for the greedy longest-match tokenizer.
package vocab_tokenizer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHK_END,
    ENTRY,
    FETCH,
    CMP,
    SKIP,
    EMIT,
    DONE
  } state_t;

  localparam logic [7:0] NULL_CHAR = 8'h00;

  function automatic logic [7:0] fold_char(input logic [7:0] c);
    return (c >= 8'h41 && c <= 8'h5A) ? (c | 8'h20) : c;
  endfunction

endpackage

// File: rtl/vocab_tokenizer_ram.sv
// Simple dual-port RAM: one write port, one read port with registered (1-cycle) read data.
module tok_ram #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/vocab_tokenizer.sv
// Greedy longest-match tokenizer over a packed null-terminated vocab RAM.
// Optional macro VOCAB_TOKENIZER_CASE_FOLD_EN enables ASCII case-insensitive compare.
module vocab_tokenizer
  import vocab_tokenizer_pkg::*;
#(
  parameter int DATA_WIDTH       = 8,
  parameter int VOCAB_ADDR_WIDTH = 8,
  parameter int INPUT_ADDR_WIDTH = 6,
  parameter int TOKEN_WIDTH      = 8,
  parameter logic [TOKEN_WIDTH-1:0] UNK_ID = '1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cs,
  input  logic                        vocab_we,
  input  logic [VOCAB_ADDR_WIDTH-1:0] vocab_waddr,
  input  logic [DATA_WIDTH-1:0]       vocab_wdata,
  input  logic                        in_we,
  input  logic [INPUT_ADDR_WIDTH-1:0] in_waddr,
  input  logic [DATA_WIDTH-1:0]       in_wdata,
  output logic                        tok_valid,
  input  logic                        tok_ready,
  output logic [TOKEN_WIDTH-1:0]      tok_id,
  output logic [INPUT_ADDR_WIDTH:0]   tok_len,
  output logic [INPUT_ADDR_WIDTH-1:0] tok_pos,
  output logic                        busy,
  output logic                        done,
  output logic                        vocab_overflow
);

  localparam int VW = VOCAB_ADDR_WIDTH;
  localparam int IW = INPUT_ADDR_WIDTH;
  localparam logic [DATA_WIDTH-1:0] NUL = DATA_WIDTH'(NULL_CHAR);

  state_t                 state_q, state_d;
  logic [IW:0]            pos_q, pos_d, ai_q, ai_d, len_q, len_d, best_len_q, best_len_d;
  logic [TOKEN_WIDTH-1:0] best_id_q, best_id_d, entry_q, entry_d;
  logic [VW-1:0]          base_q, base_d, av_q, av_d;
  logic                   tok_valid_q, tok_valid_d, busy_q, busy_d, done_q, done_d;
  logic                   ovf_q, ovf_d;
  logic [TOKEN_WIDTH-1:0] tok_id_q, tok_id_d;
  logic [IW:0]            tok_len_q, tok_len_d;
  logic [IW-1:0]          tok_pos_q, tok_pos_d;

  logic [DATA_WIDTH-1:0]  vocab_rdata, in_rdata, v_char, i_char, v_cmp, i_cmp;
  logic                   chars_eq, next_entry, go_emit;

  // Read addresses follow the next-state pointers, so rdata always reflects the current pointers.
  tok_ram #(.ADDR_WIDTH(VW), .DATA_WIDTH(DATA_WIDTH)) vocab_ram (
    .clk(clk), .we(vocab_we && !busy_q), .waddr(vocab_waddr), .wdata(vocab_wdata),
    .raddr(av_d), .rdata(vocab_rdata)
  );

  tok_ram #(.ADDR_WIDTH(IW), .DATA_WIDTH(DATA_WIDTH)) input_ram (
    .clk(clk), .we(in_we && !busy_q), .waddr(in_waddr), .wdata(in_wdata),
    .raddr(ai_d[IW-1:0]), .rdata(in_rdata)
  );

  assign v_char = vocab_rdata;
  assign i_char = ai_q[IW] ? NUL : in_rdata;

`ifdef VOCAB_TOKENIZER_CASE_FOLD_EN
  if (DATA_WIDTH != 8) begin : g_fold_width_check
    $error("vocab_tokenizer: case folding requires DATA_WIDTH == 8");
  end
  assign v_cmp = DATA_WIDTH'(fold_char(8'(v_char)));
  assign i_cmp = DATA_WIDTH'(fold_char(8'(i_char)));
`else
  assign v_cmp = v_char;
  assign i_cmp = i_char;
`endif

  assign chars_eq = (v_cmp == i_cmp);

  always_comb begin
    state_d = state_q;  pos_d = pos_q;  ai_d = ai_q;  len_d = len_q;
    best_len_d = best_len_q;  best_id_d = best_id_q;  entry_d = entry_q;
    base_d = base_q;  av_d = av_q;  ovf_d = ovf_q;
    tok_valid_d = tok_valid_q;  tok_id_d = tok_id_q;  tok_len_d = tok_len_q;
    tok_pos_d = tok_pos_q;  busy_d = busy_q;  done_d = done_q;
    next_entry = 1'b0;
    go_emit = 1'b0;

    case (state_q)
      IDLE: if (cs) begin
        pos_d = '0;  ai_d = '0;  busy_d = 1'b1;  ovf_d = 1'b0;  state_d = CHK_END;
      end
      CHK_END: if (pos_q[IW] || i_char == NUL) begin
        busy_d = 1'b0;  done_d = 1'b1;  state_d = DONE;
      end else begin
        best_len_d = '0;  best_id_d = UNK_ID;  entry_d = '0;  base_d = '0;  state_d = ENTRY;
      end
      ENTRY: begin
        av_d = base_q;  ai_d = pos_q;  len_d = '0;  state_d = FETCH;
      end
      FETCH: state_d = CMP;
      CMP: if (v_char == NUL) begin
        if (len_q == '0) go_emit = 1'b1;
        else begin
          if (len_q > best_len_q) begin
            best_id_d = entry_q;  best_len_d = len_q;
          end
          next_entry = 1'b1;
        end
      end else if (av_q == '1) begin
        ovf_d = 1'b1;  go_emit = 1'b1;
      end else begin
        av_d = av_q + 1'b1;
        if (chars_eq) begin
          ai_d = ai_q + 1'b1;  len_d = len_q + 1'b1;  state_d = FETCH;
        end else state_d = SKIP;
      end
      SKIP: if (v_char == NUL) next_entry = 1'b1;
      else if (av_q == '1) begin
        ovf_d = 1'b1;  go_emit = 1'b1;
      end else av_d = av_q + 1'b1;
      EMIT: if (tok_ready) begin
        tok_valid_d = 1'b0;  pos_d = pos_q + tok_len_q;  ai_d = pos_q + tok_len_q;
        state_d = CHK_END;
      end
      DONE: begin
        done_d = 1'b0;  state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A null at the very top address leaves nowhere for a further entry to start.
    if (next_entry) begin
      entry_d = entry_q + 1'b1;
      base_d  = av_q + 1'b1;
      if (entry_d == UNK_ID || av_q == '1) go_emit = 1'b1;
      else state_d = ENTRY;
    end

    if (go_emit) begin
      state_d     = EMIT;
      tok_valid_d = 1'b1;
      tok_id_d    = best_id_d;
      tok_len_d   = (best_len_d == '0) ? {{IW{1'b0}}, 1'b1} : best_len_d;
      tok_pos_d   = pos_q[IW-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;  pos_q <= '0;  ai_q <= '0;  len_q <= '0;
      best_len_q <= '0;  best_id_q <= '0;  entry_q <= '0;  base_q <= '0;  av_q <= '0;
      ovf_q <= 1'b0;  tok_valid_q <= 1'b0;  tok_id_q <= '0;  tok_len_q <= '0;
      tok_pos_q <= '0;  busy_q <= 1'b0;  done_q <= 1'b0;
    end else begin
      state_q <= state_d;  pos_q <= pos_d;  ai_q <= ai_d;  len_q <= len_d;
      best_len_q <= best_len_d;  best_id_q <= best_id_d;  entry_q <= entry_d;
      base_q <= base_d;  av_q <= av_d;  ovf_q <= ovf_d;
      tok_valid_q <= tok_valid_d;  tok_id_q <= tok_id_d;  tok_len_q <= tok_len_d;
      tok_pos_q <= tok_pos_d;  busy_q <= busy_d;  done_q <= done_d;
    end
  end

  assign tok_valid      = tok_valid_q;
  assign tok_id         = tok_id_q;
  assign tok_len        = tok_len_q;
  assign tok_pos        = tok_pos_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign vocab_overflow = ovf_q;

endmodule

// File: doc/vocab_tokenizer.md
Name: vocab_tokenizer

Overview:
Greedy longest-match tokenizer, parametrised successor of the single-entry matcher inside the encoder. It holds a vocab RAM of null-terminated strings packed back to back, terminated by an empty string, and an input RAM holding one null-terminated string. On start it walks the input and emits one token per step (entry index, length, position) on a valid/ready stream. It then pulses done and feeds the downstream embedding stage.

Parameters:
DATA_WIDTH, 8, character width; 0 is the null terminator.
VOCAB_ADDR_WIDTH, 8, vocab RAM address width (2^W characters).
INPUT_ADDR_WIDTH, 6, input RAM address width.
TOKEN_WIDTH, 8, token id width.
UNK_ID, 2^TOKEN_WIDTH-1, id emitted when no entry matches.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
cs  in  1  start; sampled only in IDLE
vocab_we  in  1  vocab write strobe
vocab_waddr  in  VOCAB_ADDR_WIDTH  vocab write address
vocab_wdata  in  DATA_WIDTH  vocab write data
in_we  in  1  input write strobe
in_waddr  in  INPUT_ADDR_WIDTH  input write address
in_wdata  in  DATA_WIDTH  input write data
tok_valid  out  1  token available
tok_ready  in  1  downstream accepts
tok_id  out  TOKEN_WIDTH  matched entry index or UNK_ID
tok_len  out  INPUT_ADDR_WIDTH+1  characters consumed
tok_pos  out  INPUT_ADDR_WIDTH  input start position
busy  out  1  high from start until done
done  out  1  one-cycle pulse at end of input
vocab_overflow  out  1  sticky; vocab ran past its top address without a terminator; cleared by next cs

Behaviour:
- Reset: all outputs 0, FSM IDLE, pos/best registers 0. RAM contents are not cleared.
- RAMs are 1W1R with synchronous read (1-cycle latency). Writes while busy are dropped.
- FSM states: IDLE -> CHK_END -> ENTRY -> FETCH -> CMP -> (SKIP) -> EMIT -> CHK_END ... -> DONE -> IDLE.
- IDLE: on cs, set pos=0, assert busy, clear vocab_overflow, go to CHK_END. cs is ignored in any other state.
- CHK_END: read input[pos]. If it is null, or pos has wrapped past the top address, go to DONE. Otherwise clear best_len, set best_id=UNK_ID, entry=0, base=0, go to ENTRY.
- ENTRY: set av=base, ai=pos, len=0, go to FETCH.
- FETCH: issue reads for av and ai. CMP evaluates them the next cycle, so each character compare costs 2 cycles.
- CMP, vocab char null with len==0: end of vocab, go to EMIT.
- CMP, vocab char null with len>0: full entry matched. If len>best_len, latch best_id=entry and best_len=len. Equal length keeps the earlier entry. Then set entry++, base=av+1, go to ENTRY.
- CMP, characters equal and non-null: av++, ai++, len++, go to FETCH. An input null never equals a non-null vocab char.
- CMP, mismatch: go to SKIP, which advances av one per cycle until a vocab null, then entry++, base=av+1, go to ENTRY.
- Scan end: entry==UNK_ID ends the scan (go to EMIT).
- Vocab overflow: av would wrap during CMP or SKIP -> set vocab_overflow and treat it as end of vocab.
- Input wrap: ai reaching the top address is treated as a terminator.
- EMIT: tok_valid=1 with tok_id=best_id, tok_len=max(best_len,1), tok_pos=pos. Outputs are held stable until tok_valid&&tok_ready. On acceptance: pos += tok_len, tok_valid=0 next cycle, go to CHK_END.
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE.
- Reset asserted mid-operation: immediate return to the reset state; any in-flight token is discarded.

Optional Feature:
VOCAB_TOKENIZER_CASE_FOLD_EN:
- Defined: compare is ASCII case-insensitive; 'A'..'Z' fold to 'a'..'z' on both operands before the equality test. Requires DATA_WIDTH==8 (elaboration error otherwise).
- Undefined: exact bitwise compare.

Decomposition:
- Package vocab_tokenizer_pkg holds:
  - the state_t enum;
  - the NULL_CHAR constant;
  - a fold_char function, used only under the macro.
- Sub-module tok_ram: parametrised 1W1R synchronous-read RAM (ADDR_WIDTH, DATA_WIDTH), instantiated twice as vocab_ram and input_ram.

Test Plan:
- Vocab "a","ab","abc",end; input "abcab" -> (id2,len3,pos0), (id1,len2,pos3), then done pulse; busy low after done.
- Vocab "x",end; input "q" -> (id255,len1,pos0), done.
- Empty input (input[0]=0) -> no tok_valid; done within 3 cycles of cs.
- Vocab "ab","ab",end; input "ab"; tok_ready low 5 cycles -> tok_id=0, len=2 held stable for 5 cycles; accepted on first ready cycle.
- Vocab filling all 256 addresses with no terminator; input "z" -> vocab_overflow=1, token (255,1,0), done.
- rst pulsed during SKIP of test 1, then cs -> all outputs 0 during rst; identical token stream to test 1 afterwards.
